// File: rtl/sync_frame_ctrl.sv
// rtl/sync_frame_ctrl.sv - wake-up qualified sync front end generating one divided-clock frame
// Optional comp_out glitch qualification is enabled by defining SYNC_GLITCH_FILTER_EN.
module sync_frame_ctrl #(
  parameter int CLK_DIV       = 100,
  parameter int TIMEOUT_TICKS = 20000,
  parameter int FRAME_BITS    = 1000,
  parameter int PREAMBLE_BITS = 192,
  parameter int CNT_W         = 20,
  parameter int SYNC_STAGES   = 3,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             wake_up,
  input  logic             comp_out,
  output logic             wu_valid,
  output logic             data_clk_en,
  output logic             data_clk,
  output logic             bit_strobe,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             tx_bit,
  output logic             timeout,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] FRAME_N    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] PRE_N      = CNT_W'(PREAMBLE_BITS);

  if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0) || (SYNC_STAGES < 3) || (GLITCH_CYCLES < 1) ||
      (PREAMBLE_BITS > FRAME_BITS)) begin : g_param_check
    $error("sync_frame_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       timer;
  logic [CNT_W-1:0]       div_cnt;
  logic [SYNC_STAGES-1:0] wake_sync;
  logic [SYNC_STAGES-1:0] comp_sync;
  logic                   wake_rise;
  logic                   comp_rise;
  logic                   sync_edge;

  // Bit 0 takes the raw input; the two oldest stages form the edge detector.
  always_ff @(posedge clki) begin
    if (rst) begin
      wake_sync <= '0;
      comp_sync <= '0;
    end else begin
      wake_sync <= {wake_sync[SYNC_STAGES-2:0], wake_up};
      comp_sync <= {comp_sync[SYNC_STAGES-2:0], comp_out};
    end
  end

  assign wake_rise = wake_sync[SYNC_STAGES-2] & ~wake_sync[SYNC_STAGES-1];
  assign comp_rise = comp_sync[SYNC_STAGES-2] & ~comp_sync[SYNC_STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
  localparam logic [CNT_W-1:0] QUAL_N = CNT_W'(GLITCH_CYCLES);

  logic [CNT_W-1:0] qual_cnt;
  logic [CNT_W-1:0] qual_next;

  // The rising-edge cycle counts as the first high cycle; the count saturates at QUAL_N.
  always_comb begin
    qual_next = qual_cnt;
    if (!comp_sync[SYNC_STAGES-2])
      qual_next = '0;
    else if (comp_rise)
      qual_next = CNT_W'(1);
    else if ((qual_cnt != '0) && (qual_cnt != QUAL_N))
      qual_next = qual_cnt + 1'b1;
  end

  always_ff @(posedge clki) begin
    if (rst) qual_cnt <= '0;
    else     qual_cnt <= qual_next;
  end

  assign sync_edge = (qual_next == QUAL_N) && (qual_cnt != QUAL_N);
`else
  assign sync_edge = comp_rise;
`endif

  always_ff @(posedge clki) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      div_cnt     <= '0;
      wu_valid    <= 1'b0;
      data_clk_en <= 1'b0;
      data_clk    <= 1'b0;
      bit_strobe  <= 1'b0;
      bit_cnt     <= '0;
      tx_bit      <= 1'b0;
      timeout     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      timeout    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wake_rise) begin
            state    <= ARMED;
            timer    <= '0;
            wu_valid <= 1'b1;
          end
        end
        ARMED: begin
          // A sync edge on the final window cycle beats the timeout.
          if (sync_edge) begin
            state       <= RUN;
            wu_valid    <= 1'b0;
            data_clk_en <= 1'b1;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            data_clk    <= 1'b0;
            tx_bit      <= 1'b0;
          end else if (wake_rise) begin
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state    <= IDLE;
            wu_valid <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt  <= '0;
            data_clk <= ~data_clk;
            if (!data_clk) begin
              bit_strobe <= 1'b1;
              bit_cnt    <= bit_cnt + 1'b1;
              // Post-preamble bits alternate starting with 1.
              tx_bit     <= (bit_cnt < PRE_N) ? 1'b0 : ~(bit_cnt[0] ^ PRE_N[0]);
            end else if (bit_cnt == FRAME_N) begin
              state       <= IDLE;
              data_clk_en <= 1'b0;
              frame_done  <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_ctrl.sv
// tb/tb_sync_frame_ctrl.sv - randomized self-checking bench for sync_frame_ctrl
module tb_sync_frame_ctrl;

  localparam int CD    = 4;
  localparam int TO    = 20;
  localparam int FB    = 8;
  localparam int PB    = 3;
  localparam int CNT_W = 8;
  localparam int SS    = 3;
  localparam int GC    = 4;
  localparam int HALF  = CD / 2;
  localparam int FL    = FB * CD;
  localparam int VW    = 7 + CNT_W;
`ifdef SYNC_GLITCH_FILTER_EN
  localparam int SL    = SS + GC - 1;
  localparam int MINW  = GC;
`else
  localparam int SL    = SS;
  localparam int MINW  = 1;
`endif

  logic             clki = 1'b0;
  logic             rst = 1'b1;
  logic             wake_up = 1'b0;
  logic             comp_out = 1'b0;
  logic             wu_valid, data_clk_en, data_clk, bit_strobe, tx_bit, timeout, frame_done;
  logic [CNT_W-1:0] bit_cnt;
  logic [VW-1:0]    obs;
  logic [VW-1:0]    exp_v;

  int   vecs = 0;
  int   errs = 0;
  int   held_cnt = 0;
  logic held_tx = 1'b0;

  sync_frame_ctrl #(
    .CLK_DIV(CD), .TIMEOUT_TICKS(TO), .FRAME_BITS(FB), .PREAMBLE_BITS(PB),
    .CNT_W(CNT_W), .SYNC_STAGES(SS), .GLITCH_CYCLES(GC)
  ) dut (
    .clki(clki), .rst(rst), .wake_up(wake_up), .comp_out(comp_out),
    .wu_valid(wu_valid), .data_clk_en(data_clk_en), .data_clk(data_clk),
    .bit_strobe(bit_strobe), .bit_cnt(bit_cnt), .tx_bit(tx_bit),
    .timeout(timeout), .frame_done(frame_done)
  );

  always #5 clki = ~clki;

  assign obs = {wu_valid, data_clk_en, data_clk, bit_strobe, tx_bit, timeout, frame_done, bit_cnt};

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  function automatic logic [VW-1:0] mk(logic wu, logic en, logic dclk, logic stb, logic tx,
                                       logic to, logic fd, int cnt);
    logic [CNT_W-1:0] cv;
    cv = CNT_W'(cnt);
    return {wu, en, dclk, stb, tx, to, fd, cv};
  endfunction

  function automatic logic pat(int i);
    return (i < PB) ? 1'b0 : ((i - PB) % 2 == 0);
  endfunction

  // Expected outputs at edge t given the edges where ARMED/RUN begin and the timeout fires (-1 = never).
  function automatic logic [VW-1:0] expect_at(int t, int arm, int run, int to_at);
    int rel, n;
    if (run >= 0 && t >= run && t <= run + FL) begin
      rel = t - run;
      n = (rel < HALF) ? 0 : (rel - HALF) / CD + 1;
      if (n > FB) n = FB;
      return mk(1'b0, rel < FL, (rel < FL) && ((rel / HALF) % 2 == 1),
                (rel < FL) && (rel >= HALF) && ((rel - HALF) % CD == 0),
                (n == 0) ? 1'b0 : pat(n - 1), 1'b0, rel == FL, n);
    end
    if (run >= 0 && t > run + FL) return mk(0, 0, 0, 0, pat(FB - 1), 0, 0, FB);
    if (to_at >= 0 && t == to_at) return mk(0, 0, 0, 0, held_tx, 1, 0, held_cnt);
    if (arm >= 0 && t >= arm && (run < 0 || t < run) && (to_at < 0 || t < to_at))
      return mk(1, 0, 0, 0, held_tx, 0, 0, held_cnt);
    return mk(0, 0, 0, 0, held_tx, 0, 0, held_cnt);
  endfunction

  task automatic test_reset();
    rst = 1'b1; wake_up = 1'b0; comp_out = 1'b0;
    tick(); tick();
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL reset_state got %b expected %b", obs, {VW{1'b0}}); end
    rst = 1'b0;
    held_cnt = 0; held_tx = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      exp_v = expect_at(t + 1, -1, -1, -1); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL reset_idle edge %0d got %b expected %b", t + 1, obs, exp_v); end
    end
  endtask

  task automatic test_nominal(input int iters);
    int c, ww, cw, r;
    for (int k = 0; k < iters; k++) begin
      ww = $urandom_range(3, 1);
      c  = (k == 0) ? 5 : $urandom_range(TO + SS - SL - 1, 1);
      cw = $urandom_range(30, MINW + 2);
      r  = c + SL;
      for (int t = 0; t < r + FL + 4; t++) begin
        wake_up  = (t < ww);
        comp_out = (t >= c) && (t < c + cw);
        tick();
        exp_v = expect_at(t + 1, SS, r, -1); vecs++;
        if (obs !== exp_v) begin errs++; $display("FAIL nominal c=%0d edge %0d got %b expected %b", c, t + 1, obs, exp_v); end
      end
      held_cnt = FB; held_tx = pat(FB - 1);
      wake_up = 1'b0; comp_out = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int w0, a, to_at;
    w0 = $urandom_range(5, 0);
    a = w0 + SS;
    to_at = a + TO;
    for (int t = 0; t < to_at + 20; t++) begin
      wake_up  = (t >= w0) && (t < w0 + 2);
      comp_out = (t >= to_at + 2) && (t < to_at + 10);
      tick();
      exp_v = expect_at(t + 1, a, -1, to_at); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL timeout edge %0d got %b expected %b", t + 1, obs, exp_v); end
    end
    wake_up = 1'b0; comp_out = 1'b0;
  endtask

  task automatic test_retrigger();
    int rt, t2, to_at, c, run;
    for (int k = 0; k < 3; k++) begin
      rt = (k == 0) ? 15 : $urandom_range(18, 2);
      t2 = rt + 1;
      to_at = t2 + SS + TO;
      for (int t = 0; t < to_at + 5; t++) begin
        wake_up = (t == 0) || (t == t2);
        tick();
        exp_v = expect_at(t + 1, SS, -1, to_at); vecs++;
        if (obs !== exp_v) begin errs++; $display("FAIL retrigger rt=%0d edge %0d got %b expected %b", rt, t + 1, obs, exp_v); end
      end
    end
    // off=1: sync edge one cycle too late; off=0: sync edge on the last window cycle.
    for (int off = 1; off >= 0; off--) begin
      c = SS + TO - SL + off;
      run = (off == 0) ? SS + TO : -1;
      to_at = (off == 0) ? -1 : SS + TO;
      for (int t = 0; t < SS + TO + FL + 6; t++) begin
        wake_up  = (t == 0);
        comp_out = (t >= c) && (t < c + 8);
        tick();
        exp_v = expect_at(t + 1, SS, run, to_at); vecs++;
        if (obs !== exp_v) begin errs++; $display("FAIL window_edge off=%0d edge %0d got %b expected %b", off, t + 1, obs, exp_v); end
      end
      if (run >= 0) begin held_cnt = FB; held_tx = pat(FB - 1); end
      comp_out = 1'b0;
    end
  endtask

  task automatic test_ignored();
    int c, r;
    for (int t = 0; t < 20; t++) begin
      wake_up = 1'b0;
      comp_out = (t >= 2) && (t < 12);
      tick();
      exp_v = expect_at(t + 1, -1, -1, -1); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL idle_sync edge %0d got %b expected %b", t + 1, obs, exp_v); end
    end
    c = $urandom_range(8, 2);
    r = c + SL;
    for (int t = 0; t < r + FL + 4; t++) begin
      wake_up  = (t == 0) || ((t >= r + 1) && (t < r + 3)) || (t == r + 20);
      comp_out = ((t >= c) && (t < r + 2)) || ((t >= r + 6) && (t < r + 14));
      tick();
      exp_v = expect_at(t + 1, SS, r, -1); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL run_ignore edge %0d got %b expected %b", t + 1, obs, exp_v); end
    end
    held_cnt = FB; held_tx = pat(FB - 1);
    wake_up = 1'b0; comp_out = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int c, r;
    c = $urandom_range(10, 1);
    r = c + SL;
    for (int t = 0; t < r + 14; t++) begin
      wake_up  = (t == 0);
      comp_out = (t >= c) && (t < c + MINW + 2);
      tick();
      exp_v = expect_at(t + 1, SS, r, -1); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL pre_reset edge %0d got %b expected %b", t + 1, obs, exp_v); end
    end
    rst = 1'b1; comp_out = 1'b0; wake_up = 1'b0;
    tick();
    rst = 1'b0;
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL mid_run_reset got %b expected %b", obs, {VW{1'b0}}); end
    held_cnt = 0; held_tx = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      exp_v = expect_at(t + 1, -1, -1, -1); vecs++;
      if (obs !== exp_v) begin errs++; $display("FAIL post_reset edge %0d got %b expected %b", t + 1, obs, exp_v); end
    end
  endtask

  task automatic test_glitch();
    int w, c, run, to_at;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       w = 3;
        1:       w = 4;
        2:       w = $urandom_range(9, 5);
        default: w = $urandom_range(3, 1);
      endcase
      c = $urandom_range(8, 1);
      run = (w >= MINW) ? c + SL : -1;
      to_at = (run < 0) ? SS + TO : -1;
      for (int t = 0; t < SS + TO + FL + 8; t++) begin
        wake_up  = (t == 0);
        comp_out = (t >= c) && (t < c + w);
        tick();
        exp_v = expect_at(t + 1, SS, run, to_at); vecs++;
        if (obs !== exp_v) begin errs++; $display("FAIL glitch w=%0d edge %0d got %b expected %b", w, t + 1, obs, exp_v); end
      end
      if (run >= 0) begin held_cnt = FB; held_tx = pat(FB - 1); end
      comp_out = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_nominal(4);
    test_timeout();
    test_retrigger();
    test_ignored();
    test_reset_mid_run();
    test_nominal(1);
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sync_frame_ctrl.md
Name: sync_frame_ctrl

Overview:
- Parametrised wake-up / synchronisation front end for the receive path.
- Qualifies an asynchronous wake-up event and opens a bounded window for the first comparator (stage-2) rising edge. On that edge it generates a divided data clock for exactly one frame of FRAME_BITS bits.
- Drives a per-bit test pattern: a zero preamble followed by alternating bits.
- Successor to the fixed 100-divider / 1000-bit / 192-preamble sync block. Adds programmable sizes, a reset, an explicit FSM, timeout reporting, retrigger and frame-done signalling.

Parameters:
- CLK_DIV, 100: system clocks per data-clock period. Must be even and >= 2.
- TIMEOUT_TICKS, 20000: length of the ARMED window in clki cycles (200 us at 100 MHz).
- FRAME_BITS, 1000: data-clock rising edges per frame.
- PREAMBLE_BITS, 192: leading bits of the frame with tx_bit = 0. Must be <= FRAME_BITS.
- CNT_W, 20: counter width. Must hold TIMEOUT_TICKS, FRAME_BITS and CLK_DIV.
- SYNC_STAGES, 3: synchroniser depth per async input. Must be >= 3.
- GLITCH_CYCLES, 4: qualification length, used only when SYNC_GLITCH_FILTER_EN is defined.

Ports:
- clki, in, 1: system clock, 100 MHz.
- rst, in, 1: synchronous, active-high reset.
- wake_up, in, 1: asynchronous wake-up detector output.
- comp_out, in, 1: asynchronous stage-2 comparator output.
- wu_valid, out, 1: high while ARMED (wake-up accepted, awaiting sync edge).
- data_clk_en, out, 1: high while RUN.
- data_clk, out, 1: divided data clock. Low outside RUN.
- bit_strobe, out, 1: one-cycle pulse coincident with each data_clk 0->1 transition.
- bit_cnt, out, CNT_W: number of data-clock rising edges in the current frame.
- tx_bit, out, 1: pattern bit, updated on bit_strobe.
- timeout, out, 1: one-cycle pulse when the ARMED window expires.
- frame_done, out, 1: one-cycle pulse when a frame completes.

Behaviour:
- Reset: while rst is high at a clki edge, all outputs, counters and synchroniser flops go to 0 and the state goes to IDLE. Applies from any state; RUN is abandoned with data_clk = 0 on the next edge.
- Synchronisers: wake_up and comp_out each pass through a SYNC_STAGES flop chain. A rising edge is the last two stages equal to 01. The edge is acted on SYNC_STAGES-1 edges after the input is first sampled high.
- IDLE:
  - Wake edge -> ARMED; timer = 0.
  - Sync edges are ignored.
- ARMED:
  - wu_valid = 1; timer increments by 1 per cycle.
  - Sync edge -> RUN: div_cnt = 0, bit_cnt = 0, data_clk = 0, tx_bit = 0.
  - Timer == TIMEOUT_TICKS-1 with no sync edge -> IDLE with a timeout pulse. If a sync edge arrives on that same cycle, the sync edge wins and there is no timeout.
  - Wake edge while ARMED (no sync edge) restarts the timer at 0 (retrigger).
- RUN:
  - data_clk_en = 1; wake and sync edges are ignored.
  - div_cnt increments each cycle. When div_cnt == CLK_DIV/2-1: data_clk toggles and div_cnt = 0.
  - The first data_clk rise is registered CLK_DIV/2 cycles after RUN entry.
  - On each 0->1 toggle:
    - bit_strobe = 1 and bit_cnt += 1.
    - With i = old bit_cnt: tx_bit = 0 if i < PREAMBLE_BITS, else tx_bit = ~(i-PREAMBLE_BITS)[0]. The first post-preamble bit is 1.
  - On the 1->0 toggle with bit_cnt == FRAME_BITS -> IDLE, with a frame_done pulse and data_clk_en = 0.
  - bit_cnt and tx_bit hold their values until the next RUN entry.
  - Frame length is exactly FRAME_BITS*CLK_DIV cycles from RUN entry to the frame_done cycle inclusive.
- All outputs are registered. There are no combinational paths from input to output.

Optional Feature:
- SYNC_GLITCH_FILTER_EN defined:
  - A sync edge is accepted only after synchronised comp_out has been high for GLITCH_CYCLES consecutive cycles.
  - The qualification counter clears on any low sample. Acceptance occurs on the cycle the count reaches GLITCH_CYCLES; the rising edge itself is the first counted cycle.
  - Acceptance must still fall inside the ARMED window.
- Undefined: the raw synchronised rising edge is used, and the GLITCH_CYCLES parameter is unused.

Test Plan (CLK_DIV=4, TIMEOUT_TICKS=20, FRAME_BITS=8, PREAMBLE_BITS=3, SYNC_STAGES=3):
1. Nominal frame. Wake pulse, then comp_out rises 5 cycles later.
   - Expect: wu_valid high until RUN entry, then data_clk period of 4 cycles.
   - Expect: 8 bit_strobes, tx_bit sequence 0,0,0,1,0,1,0,1.
   - Expect: frame_done exactly 32 cycles after RUN entry; bit_cnt = 8.
2. Timeout. Wake pulse, no comp_out.
   - Expect: timeout pulse 20 cycles after ARMED entry, then IDLE.
   - Expect: a later comp_out edge produces no data_clk.
3. Retrigger and same-cycle priority.
   - Wake edge at timer = 15 -> timer restarts; timeout occurs 20 cycles after the second wake edge.
   - Sync edge on the timer = 19 cycle -> RUN entered, no timeout pulse.
4. Ignored events. Extra wake_up and comp_out edges during RUN and in IDLE (no prior wake).
   - Expect: frame unaffected; no state change from IDLE.
5. Reset mid-RUN. Assert rst for 1 cycle at bit_cnt = 4.
   - Expect: next edge all outputs 0, IDLE; no frame_done.
   - A new wake plus sync then produces a full 8-bit frame.
6. SYNC_GLITCH_FILTER_EN defined.
   - comp_out high for 3 cycles then low -> no RUN.
   - comp_out high for 4 or more cycles -> RUN entered on the 4th synchronised-high cycle.
